// File: rtl/merge_layer_scheduler.sv
// Sequences up to NUM_PAIRS run pairs of one merge layer through a shared 2:1 merge unit.
// Optional watchdog compiled in with `define MERGE_TIMEOUT_EN.
module merge_layer_scheduler #(
    parameter int NUM_PAIRS = 4,
    parameter int PAIR_W    = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PAIR_W:0]   pair_cnt,
    output logic              mrg_load,
    input  logic              mrg_done,
    output logic [PAIR_W-1:0] pair_idx,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    if (PAIR_W != $clog2(NUM_PAIRS) || TIMEOUT < 1) begin : g_param_check
        $error("merge_layer_scheduler: PAIR_W must equal clog2(NUM_PAIRS) and TIMEOUT must be >= 1");
    end

    localparam logic [PAIR_W:0] MAX_CNT = (PAIR_W + 1)'(NUM_PAIRS);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_LOW, WAIT_HIGH, WRITE, FINISH
    } state_t;

    state_t            state, state_nx;
    logic [PAIR_W:0]   cnt, cnt_clamped;
    logic [PAIR_W-1:0] idx_nx;
    logic              last_pair;
    logic              wd_expired;
    logic              load_nx, wr_nx, busy_nx, done_nx;

    assign cnt_clamped = (pair_cnt > MAX_CNT) ? MAX_CNT : pair_cnt;
    assign last_pair   = ({1'b0, pair_idx} == (cnt - 1'b1));

`ifdef MERGE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Counts only wait cycles of the current pair; restarted by every load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == LOAD) begin
            wd_cnt <= '0;
        end else if (state == WAIT_LOW || state == WAIT_HIGH) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_expired = (state == WAIT_LOW || state == WAIT_HIGH) &&
                        (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (state == IDLE && start) begin
            timeout_q <= 1'b0;
        end else if (wd_expired && state_nx == FINISH) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // WAIT_LOW swallows the stale done level left over from the previous merge.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = (cnt_clamped == '0) ? FINISH : LOAD;
            LOAD:      state_nx = WAIT_LOW;
            WAIT_LOW: begin
                if (wd_expired)     state_nx = FINISH;
                else if (!mrg_done) state_nx = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (mrg_done)        state_nx = WRITE;
                else if (wd_expired) state_nx = FINISH;
            end
            WRITE:     state_nx = last_pair ? FINISH : LOAD;
            FINISH:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        load_nx = (state_nx == LOAD);
        wr_nx   = (state_nx == WRITE);
        done_nx = (state_nx == FINISH);
        busy_nx = (state_nx == LOAD) || (state_nx == WAIT_LOW) ||
                  (state_nx == WAIT_HIGH) || (state_nx == WRITE);
        idx_nx  = pair_idx;
        if (state == IDLE || state_nx == IDLE) begin
            idx_nx = '0;
        end else if (state == WRITE && state_nx == LOAD) begin
            idx_nx = pair_idx + 1'b1;
        end
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrg_load <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pair_idx <= '0;
            cnt      <= '0;
        end else begin
            mrg_load <= load_nx;
            wr_en    <= wr_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pair_idx <= idx_nx;
            if (state == IDLE && start) begin
                cnt <= cnt_clamped;
            end
        end
    end

endmodule

// File: tb/tb_merge_layer_scheduler.sv
// Scoreboard bench for merge_layer_scheduler: stimulus queues expected load/write/done
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_merge_layer_scheduler;

    localparam int NUM_PAIRS = 4;
    localparam int PAIR_W    = 2;
    localparam int TIMEOUT   = 15;
    localparam int K_LOAD    = 0;
    localparam int K_WR      = 1;
    localparam int K_DONE    = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [PAIR_W:0]   pair_cnt;
    logic              mrg_load;
    logic              mrg_done;
    logic [PAIR_W-1:0] pair_idx;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic              timeout_err;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } evt_t;

    evt_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   lat        = 5;
    int   stale_hold = 0;
    bit   stuck      = 1'b0;

    merge_layer_scheduler #(
        .NUM_PAIRS(NUM_PAIRS),
        .PAIR_W   (PAIR_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pair_cnt   (pair_cnt),
        .mrg_load   (mrg_load),
        .mrg_done   (mrg_done),
        .pair_idx   (pair_idx),
        .wr_en      (wr_en),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Merge unit model: done level is kept for stale_hold cycles after a load,
    // then low, then high from lat cycles after the load onwards.
    initial begin : merge_unit
        int k;
        k = -1;
        mrg_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n)        k = -1;
            else if (mrg_load) k = 0;
            else if (k >= 0)   k++;
            if (k > stale_hold) mrg_done = !stuck && (k >= lat);
        end
    end

    function automatic void push(input int kind, input int idx, input int c);
        evt_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    task automatic check_evt(input int kind, input string name);
        evt_t e;
        int   exp_busy;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected: cycle %0d pair_idx %0d, required no event", name, cyc, pair_idx);
        end else begin
            e = exp_q.pop_front();
            exp_busy = (kind == K_DONE) ? 0 : 1;
            if (e.kind != kind || e.cyc != cyc || e.idx != int'(pair_idx) || exp_busy != int'(busy)) begin
                fails++;
                $display("FAIL %s: got kind %0d cycle %0d idx %0d busy %0d, required kind %0d cycle %0d idx %0d busy %0d",
                         name, kind, cyc, pair_idx, busy, e.kind, e.cyc, e.idx, exp_busy);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mrg_load) check_evt(K_LOAD, "mrg_load");
                if (wr_en)    check_evt(K_WR, "wr_en");
                if (done)     check_evt(K_DONE, "done");
                if (mrg_load || wr_en || done) begin
                    tests++;
                    if (int'(mrg_load) + int'(wr_en) + int'(done) > 1) begin
                        fails++;
                        $display("FAIL exclusive: load %0d wr %0d done %0d, required at most one", mrg_load, wr_en, done);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string name);
        logic [PAIR_W+4:0] got;
        got = {mrg_load, wr_en, busy, done, timeout_err, pair_idx};
        tests++;
        if (got != '0) begin
            fails++;
            $display("FAIL %s: outputs {load,wr,busy,done,terr,idx} = %b, required all 0", name, got);
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // Expected timeline: load i at s+1+i*(lat+2), write one cycle after done seen high.
    task automatic run_layer(input int cnt_in, input int lat_in, input int stale_in, input int extra_start);
        int s, n, l, w;
        lat        = lat_in;
        stale_hold = stale_in;
        stuck      = 1'b0;
        n = (cnt_in > NUM_PAIRS) ? NUM_PAIRS : cnt_in;
        @(posedge clk);
        #1;
        s = cyc;
        w = s;
        for (int i = 0; i < n; i++) begin
            l = s + 1 + i * (lat_in + 2);
            push(K_LOAD, i, l);
            w = l + lat_in + 1;
            push(K_WR, i, w);
        end
        push(K_DONE, (n > 0) ? n - 1 : 0, w + 1);
        pair_cnt = cnt_in[PAIR_W:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (extra_start > 1) begin
            repeat (extra_start - 1) @(posedge clk);
            #1;
            pair_cnt = 3'd1;
            start    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        drain(100);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int s;
        rst_n    = 1'b0;
        start    = 1'b0;
        pair_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_layer(3, 5, 0, 0);   // three pairs, merge latency 5
        run_layer(0, 5, 0, 0);   // empty layer: done the cycle after start
        run_layer(7, 3, 0, 0);   // count clamps to NUM_PAIRS
        run_layer(2, 4, 1, 0);   // stale done seen in WAIT_LOW
        run_layer(3, 5, 0, 10);  // start re-asserted while pair 1 is merging

        // Reset in WAIT_HIGH aborts the layer without write or done.
        lat = 6; stale_hold = 0; stuck = 1'b0;
        @(posedge clk);
        #1;
        s = cyc;
        push(K_LOAD, 0, s + 1);
        pair_cnt = 3'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b1 || mrg_done !== 1'b0) begin
            fails++;
            $display("FAIL pre_abort: busy %0d mrg_done %0d, required busy 1 mrg_done 0", busy, mrg_done);
        end
        rst_n = 1'b0;
        #1;
        check_zero("abort_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        drain(1);
        run_layer(1, 3, 0, 0);   // first layer after reset starts at pair 0

`ifdef MERGE_TIMEOUT_EN
        stuck = 1'b1; stale_hold = 0; lat = 5;
        @(posedge clk);
        #1;
        s = cyc;
        push(K_LOAD, 0, s + 1);
        push(K_DONE, 0, s + 2 + TIMEOUT);
        pair_cnt = 3'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(60);
        #1;
        tests++;
        if (timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_set: timeout_err %0d, required 1", timeout_err);
        end
        run_layer(1, 3, 0, 0);
        #1;
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: timeout_err %0d, required 0", timeout_err);
        end
`else
        stuck = 1'b1; stale_hold = 0; lat = 5;
        @(posedge clk);
        #1;
        s = cyc;
        push(K_LOAD, 0, s + 1);
        pair_cnt = 3'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(10);
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if ({busy, timeout_err} !== 2'b10) begin
            fails++;
            $display("FAIL stuck_wait: busy %0d timeout_err %0d, required busy 1 timeout_err 0", busy, timeout_err);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stuck = 1'b0;
        repeat (3) @(posedge clk);
`endif

        drain(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/merge_layer_scheduler.md
MERGE_LAYER_SCHEDULER -- requirements
Module: merge_layer_scheduler

Interface
REQ-001 Parameter NUM_PAIRS, default 4: maximum number of run pairs sequenced through the shared 2:1 merge unit per layer.
REQ-002 Parameter PAIR_W, default 2: width of pair_idx; SHALL equal clog2(NUM_PAIRS).
REQ-003 Parameter TIMEOUT, default 15: watchdog limit in cycles; used only when MERGE_TIMEOUT_EN is defined.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to merge one layer.
REQ-007 pair_cnt  input  PAIR_W+1  number of pairs to merge; sampled only when start is accepted.
REQ-008 mrg_load  output  1  single-cycle load pulse to the merge unit.
REQ-009 mrg_done  input  1  level done from the merge unit; cleared by the unit after it accepts a load.
REQ-010 pair_idx  output  PAIR_W  selects the operand buffers and the result slot of the current pair.
REQ-011 wr_en  output  1  single-cycle commit of the merged result for pair_idx.
REQ-012 busy  output  1  high from start acceptance until done.
REQ-013 done  output  1  single-cycle end-of-layer pulse.
REQ-014 timeout_err  output  1  sticky watchdog flag.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have the states IDLE, LOAD, WAIT_LOW, WAIT_HIGH, WRITE and FINISH.
REQ-017 start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored with no other effect.
REQ-018 On acceptance, the pair count SHALL be latched as min(pair_cnt, NUM_PAIRS), pair_idx SHALL be set to 0 and busy SHALL rise the next cycle.
REQ-019 If the latched count is 0, the FSM SHALL go to FINISH, and done SHALL pulse the cycle after start without any mrg_load.
REQ-020 Otherwise, mrg_load SHALL be high for exactly one cycle, the cycle after start; the FSM then SHALL go to WAIT_LOW.
REQ-021 In WAIT_LOW the FSM SHALL ignore mrg_done=1 (the stale level from the previous merge) and SHALL go to WAIT_HIGH when mrg_done=0 is sampled.
REQ-022 In WAIT_HIGH, mrg_done=1 SHALL move the FSM to WRITE, and wr_en SHALL be high for one cycle with the current pair_idx.
REQ-023 After WRITE: if pair_idx = count-1, the FSM SHALL go to FINISH; otherwise pair_idx SHALL increment and mrg_load SHALL pulse the next cycle (LOAD).
REQ-024 pair_idx SHALL never wrap; it SHALL be 0 whenever the FSM is in IDLE.
REQ-025 In FINISH, done SHALL pulse for one cycle, busy SHALL fall in the same cycle and the FSM SHALL return to IDLE.
REQ-026 Per pair, latency SHALL be mrg_load -> merge-unit latency -> wr_en one cycle after mrg_done is sampled high.
REQ-027 mrg_load, wr_en and done SHALL be mutually exclusive in every cycle.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with mrg_load=0, wr_en=0, busy=0, done=0, pair_idx=0, timeout_err=0 and the latched count at 0.
REQ-029 A reset mid-layer SHALL abort the layer with no done and no wr_en; the first start after reset SHALL begin at pair 0.

Configuration
REQ-030 The macro MERGE_TIMEOUT_EN SHALL compile in the watchdog.
REQ-031 With MERGE_TIMEOUT_EN defined, a counter SHALL clear on each mrg_load and count cycles spent in WAIT_LOW/WAIT_HIGH.
REQ-032 With MERGE_TIMEOUT_EN defined, reaching TIMEOUT SHALL set timeout_err, skip wr_en and go to FINISH (done pulses).
REQ-033 With MERGE_TIMEOUT_EN defined, timeout_err SHALL be cleared on the next accepted start.
REQ-034 Without MERGE_TIMEOUT_EN, the FSM SHALL wait indefinitely, the timeout_err port SHALL remain and SHALL be tied to 0.

Verification
REQ-035 pair_cnt=3, and the model raises mrg_done 5 cycles after each load -> 3 mrg_load pulses, wr_en with pair_idx 0, 1, 2, then one done pulse; busy high throughout.
REQ-036 pair_cnt=0 -> done pulses the cycle after start, with no mrg_load and no wr_en.
REQ-037 pair_cnt=7 with NUM_PAIRS=4 -> exactly 4 merges, pair_idx 0..3, no wrap.
REQ-038 mrg_done held high from the prior merge for 1 cycle after the load -> no early wr_en; wr_en follows only the next 0->1 transition.
REQ-039 start re-asserted during pair 1 -> ignored, and the sequence is unchanged; rst_n pulsed low during WAIT_HIGH -> all outputs 0, no done.
REQ-040 With MERGE_TIMEOUT_EN defined and mrg_done stuck at 0 -> timeout_err=1 after 15 wait cycles, done pulses, no wr_en; the next start clears timeout_err.
